// File: rtl/rr_stream_arbiter_if.sv
// Stream bundle between NUM_REQ upstream sources, the round-robin arbiter and one downstream sink.
// The slave modport is the arbiter's view; the master modport is the surrounding environment's view.
interface rr_stream_arbiter_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ*WIDTH-1:0] s_tdata;
  logic [NUM_REQ-1:0]       s_tvalid;
  logic [NUM_REQ-1:0]       s_tlast;
  logic [NUM_REQ-1:0]       s_tready;
  logic [WIDTH-1:0]         m_tdata;
  logic                     m_tvalid;
  logic                     m_tlast;
  logic [ID_W-1:0]          m_tid;
  logic                     m_tready;

  modport slave (
    input  s_tdata, s_tvalid, s_tlast, m_tready,
    output s_tready, m_tdata, m_tvalid, m_tlast, m_tid
  );

  modport master (
    output s_tdata, s_tvalid, s_tlast, m_tready,
    input  s_tready, m_tdata, m_tvalid, m_tlast, m_tid
  );
endinterface

// File: rtl/rr_stream_arbiter.sv
// Round-robin stream arbiter: one grant at a time, held until tlast or MAX_BURST beats,
// feeding a single registered output stage tagged with the source index.
module rr_stream_arbiter #(
  parameter int WIDTH     = 32,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  rr_stream_arbiter_if.slave strm,
  output logic               busy
);
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e            state_q;
  logic [ID_W-1:0]   grant_q;
  logic [ID_W-1:0]   last_grant_q;
  logic [CNT_W-1:0]  count_q;
  logic [WIDTH-1:0]  m_tdata_q;
  logic              m_tvalid_q;
  logic              m_tlast_q;
  logic [ID_W-1:0]   m_tid_q;

  logic [NUM_REQ-1:0] s_tready_s;
  logic               accept_s;
  logic               release_s;
  logic               drain_s;
  logic               any_valid_s;
  logic [WIDTH-1:0]   beat_data_s;
  logic               beat_last_s;
  logic [ID_W-1:0]    pick_s;

  // Scanning offsets from high to low lets the nearest requester after 'last' win.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                              input logic [ID_W-1:0]    last);
    logic [ID_W-1:0] pick;
    int              idx;
    pick = last;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = (int'(last) + i) % NUM_REQ;
      if (req[idx]) begin
        pick = ID_W'(idx);
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  // Ready steering, beat selection and release decision for the current grant.
  always_comb begin
    s_tready_s = '0;
    if ((state_q == ST_GRANT) && (!m_tvalid_q || strm.m_tready)) begin
      s_tready_s[grant_q] = 1'b1;
    end else begin
      s_tready_s = '0;
    end
    accept_s    = |(s_tready_s & strm.s_tvalid);
    beat_data_s = strm.s_tdata[int'(grant_q)*WIDTH +: WIDTH];
    beat_last_s = strm.s_tlast[grant_q];
    release_s   = accept_s && (beat_last_s || (count_q == CNT_W'(MAX_BURST - 1)));
    drain_s     = m_tvalid_q && strm.m_tready;
    any_valid_s = |strm.s_tvalid;
    pick_s      = rr_pick(strm.s_tvalid, last_grant_q);
  end

  // Grant FSM together with the registered output stage.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      count_q      <= '0;
      m_tdata_q    <= '0;
      m_tvalid_q   <= 1'b0;
      m_tlast_q    <= 1'b0;
      m_tid_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_valid_s) begin
            grant_q <= pick_s;
            state_q <= ST_GRANT;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          // A forced rotation at MAX_BURST deliberately leaves tlast untouched.
          if (release_s) begin
            last_grant_q <= grant_q;
            count_q      <= '0;
            state_q      <= ST_IDLE;
          end else if (accept_s) begin
            count_q <= count_q + CNT_W'(1);
          end else begin
            state_q <= ST_GRANT;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase

      if (accept_s) begin
        m_tdata_q  <= beat_data_s;
        m_tlast_q  <= beat_last_s;
        m_tid_q    <= grant_q;
        m_tvalid_q <= 1'b1;
      end else if (drain_s) begin
        m_tvalid_q <= 1'b0;
      end else begin
        m_tvalid_q <= m_tvalid_q;
      end
    end
  end

  assign strm.s_tready = s_tready_s;
  assign strm.m_tdata  = m_tdata_q;
  assign strm.m_tvalid = m_tvalid_q;
  assign strm.m_tlast  = m_tlast_q;
  assign strm.m_tid    = m_tid_q;
  assign busy          = (state_q == ST_GRANT) || m_tvalid_q;

endmodule
